axi_lite_slv_frontend: RTL and testbench

AXI4-Lite slave protocol front-end for the PS GP port. It terminates the five AXI4-Lite channels and drives the flat register-file strobe interface: axi_awaddr, S_AXI_WDATA_ext and slv_reg_wren on the write side, axi_araddr and slv_reg_rden on the read side. It collects S_AXI_RDATA_ext one cycle after slv_reg_rden and returns it on the R channel. The parameter register file sits directly behind it; read and write paths are independent.

---
 rtl/axi_lite_slv_frontend_if.sv | 62 ++++++
 rtl/axi_lite_slv_frontend.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_lite_slv_frontend.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slv_frontend_if.sv
`default_nettype none
// =============================================================================
// Interface : axi_lite_slv_frontend_if
// Purpose   : AXI4-Lite bus bundle (AW, W, B, AR, R channels) between the PS GP
//             master and the register-file slave front-end.
// Revision  : 1.0 - initial release
// =============================================================================
interface axi_lite_slv_frontend_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    // Write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]                    S_AXI_AWPROT;
    logic                          S_AXI_AWVALID;
    logic                          S_AXI_AWREADY;
    // Write data channel
    logic [31:0]                   S_AXI_WDATA;
    logic [3:0]                    S_AXI_WSTRB;
    logic                          S_AXI_WVALID;
    logic                          S_AXI_WREADY;
    // Write response channel
    logic [1:0]                    S_AXI_BRESP;
    logic                          S_AXI_BVALID;
    logic                          S_AXI_BREADY;
    // Read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]                    S_AXI_ARPROT;
    logic                          S_AXI_ARVALID;
    logic                          S_AXI_ARREADY;
    // Read data channel
    logic [31:0]                   S_AXI_RDATA;
    logic [1:0]                    S_AXI_RRESP;
    logic                          S_AXI_RVALID;
    logic                          S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slv_frontend.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_slv_frontend
// Purpose  : AXI4-Lite slave protocol front-end. Terminates the five AXI4-Lite
//            channels and drives a flat register-file strobe interface with
//            independent, concurrently running write and read state machines.
// Revision : 1.0 - initial release
// =============================================================================
module axi_lite_slv_frontend #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h4000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_ADDR_SPAN        = 32'h0001_0000
) (
    input  logic                            axiclk,
    input  logic                            rst_n,
    axi_lite_slv_frontend_if.slave          s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [31:0]                     S_AXI_WDATA_ext,
    output logic                            slv_reg_wren,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    output logic                            slv_reg_rden,
    input  logic [31:0]                     S_AXI_RDATA_ext
);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_WAIT_W  = 3'd1,
        W_WAIT_AW = 3'd2,
        W_EXEC    = 3'd3,
        W_RESP    = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } rd_state_t;

    // Window check done one bit wider than the address so BASE+SPAN cannot wrap.
    function automatic logic addr_in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        logic [C_S_AXI_ADDR_WIDTH:0] lo;
        logic [C_S_AXI_ADDR_WIDTH:0] hi;
        logic [C_S_AXI_ADDR_WIDTH:0] x;
        lo = {1'b0, C_BASE_ADDR};
        hi = lo + {1'b0, C_ADDR_SPAN};
        x  = {1'b0, addr};
        return (x >= lo) && (x < hi);
    endfunction

    // ---------------------------------------------------------------------
    // Registered state and channel outputs
    // ---------------------------------------------------------------------
    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [3:0]  r_wstrb;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic        r_rd_ok;

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    // ---------------------------------------------------------------------
    // Handshakes and the address/strobe that will be current once the
    // pending handshake (if any) has been absorbed. The write strobe and
    // response are decided on the edge that enters W_EXEC, so they must look
    // through to the incoming address/strobe rather than the latched copy.
    // ---------------------------------------------------------------------
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr_algn;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_araddr_algn;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr_cur;
    logic [3:0]                    w_wstrb_cur;
    logic [1:0]                    w_wr_resp;
    logic                          w_wr_ok;
    logic                          w_rd_in_range;
    logic                          w_unused;

    assign w_aw_hs       = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs        = s_axi.S_AXI_WVALID  & r_wready;
    assign w_ar_hs       = s_axi.S_AXI_ARVALID & r_arready;
    assign w_awaddr_algn = {s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign w_araddr_algn = {s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign w_awaddr_cur  = w_aw_hs ? w_awaddr_algn : axi_awaddr;
    assign w_wstrb_cur   = w_w_hs  ? s_axi.S_AXI_WSTRB : r_wstrb;

    // Out-of-window takes priority over a partial or empty strobe.
    assign w_wr_resp = !addr_in_range(w_awaddr_cur) ? c_resp_decerr :
                       (w_wstrb_cur != 4'hF)         ? c_resp_slverr :
                                                       c_resp_okay;
    assign w_wr_ok       = (w_wr_resp == c_resp_okay);
    assign w_rd_in_range = addr_in_range(w_araddr_algn);

    // Protection bits and byte-offset bits carry no meaning for this block.
    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Write FSM: collects AW and W in either order, fires one wren, answers on B.
    always_ff @(posedge axiclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state      <= W_IDLE;
            r_awready       <= 1'b0;
            r_wready        <= 1'b0;
            r_bvalid        <= 1'b0;
            r_bresp         <= 2'b00;
            r_wstrb         <= 4'h0;
            axi_awaddr      <= '0;
            S_AXI_WDATA_ext <= 32'h0;
            slv_reg_wren    <= 1'b0;
        end else begin
            slv_reg_wren <= 1'b0;
            if (w_aw_hs) begin
                axi_awaddr <= w_awaddr_algn;
            end
            if (w_w_hs) begin
                S_AXI_WDATA_ext <= s_axi.S_AXI_WDATA;
                r_wstrb         <= s_axi.S_AXI_WSTRB;
            end
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_awready    <= 1'b0;
                        r_wready     <= 1'b0;
                        slv_reg_wren <= w_wr_ok;
                        r_bresp      <= w_wr_resp;
                        r_wr_state   <= W_EXEC;
                    end else if (w_aw_hs) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_WAIT_W;
                    end else if (w_w_hs) begin
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b0;
                        r_wr_state <= W_WAIT_AW;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_WAIT_W: begin
                    if (w_w_hs) begin
                        r_wready     <= 1'b0;
                        slv_reg_wren <= w_wr_ok;
                        r_bresp      <= w_wr_resp;
                        r_wr_state   <= W_EXEC;
                    end
                end
                W_WAIT_AW: begin
                    if (w_aw_hs) begin
                        r_awready    <= 1'b0;
                        slv_reg_wren <= w_wr_ok;
                        r_bresp      <= w_wr_resp;
                        r_wr_state   <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    r_bvalid   <= 1'b1;
                    r_wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: latches AR, fires one rden, captures register data a cycle later.
    always_ff @(posedge axiclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state   <= R_IDLE;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rresp      <= 2'b00;
            r_rdata      <= 32'h0;
            r_rd_ok      <= 1'b0;
            axi_araddr   <= '0;
            slv_reg_rden <= 1'b0;
        end else begin
            slv_reg_rden <= 1'b0;
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        axi_araddr   <= w_araddr_algn;
                        r_rd_ok      <= w_rd_in_range;
                        slv_reg_rden <= w_rd_in_range;
                        r_arready    <= 1'b0;
                        r_rd_state   <= R_EXEC;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_EXEC: begin
                    r_rd_state <= R_WAIT;
                end
                R_WAIT: begin
                    // Register file presents its data during this cycle.
                    if (r_rd_ok) begin
                        r_rdata <= S_AXI_RDATA_ext;
                        r_rresp <= c_resp_okay;
                    end else begin
                        r_rdata <= 32'h0;
                        r_rresp <= c_resp_decerr;
                    end
                    r_rvalid   <= 1'b1;
                    r_rd_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slv_frontend.sv
`default_nettype none
// =============================================================================
// Module   : tb_axi_lite_slv_frontend
// Purpose  : Directed self-checking bench for axi_lite_slv_frontend with a
//            behavioural register file behind the strobe interface.
// Revision : 1.0 - initial release
// =============================================================================
module tb_axi_lite_slv_frontend;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] axi_awaddr;
    logic [31:0] wdata_ext;
    logic        wren;
    logic [31:0] axi_araddr;
    logic        rden;
    logic [31:0] rdata_ext = 32'h0;

    logic [31:0] rf [0:16383];
    int          wren_cnt = 0;
    int          n_vec    = 0;
    int          n_err    = 0;

    axi_lite_slv_frontend_if #(.C_S_AXI_ADDR_WIDTH(32)) bus ();

    axi_lite_slv_frontend #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_BASE_ADDR        (32'h4000_0000),
        .C_ADDR_SPAN        (32'h0001_0000)
    ) dut (
        .axiclk          (clk),
        .rst_n           (rst_n),
        .s_axi           (bus.slave),
        .axi_awaddr      (axi_awaddr),
        .S_AXI_WDATA_ext (wdata_ext),
        .slv_reg_wren    (wren),
        .axi_araddr      (axi_araddr),
        .slv_reg_rden    (rden),
        .S_AXI_RDATA_ext (rdata_ext)
    );

    always #5 clk = ~clk;

    // Register file: read data appears the cycle after rden; a same-cycle
    // write lands after the read has sampled the old value.
    always @(posedge clk) begin
        if (rden) rdata_ext <= rf[axi_araddr[15:2]];
        if (wren) begin
            rf[axi_awaddr[15:2]] <= wdata_ext;
            wren_cnt             <= wren_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk("wr_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h3);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
    endtask

    // Called in the cycle after the last AW/W handshake, BREADY held high.
    task automatic wr_finish(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic exp_wren, input logic [1:0] exp_resp);
        int c0;
        c0 = wren_cnt;
        chk({tag, "_wren"},   32'(wren), 32'(exp_wren));
        chk({tag, "_awaddr"}, axi_awaddr, a & 32'hFFFF_FFFC);
        chk({tag, "_wdata"},  wdata_ext, d);
        chk({tag, "_bv_early"}, 32'(bus.S_AXI_BVALID), 32'h0);
        tick();
        chk({tag, "_wren_off"}, 32'(wren), 32'h0);
        chk({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'h1);
        chk({tag, "_bresp"},  32'(bus.S_AXI_BRESP), 32'(exp_resp));
        tick();
        chk({tag, "_bv_drop"}, 32'(bus.S_AXI_BVALID), 32'h0);
        chk({tag, "_wcount"}, 32'(wren_cnt - c0), 32'(exp_wren));
    endtask

    task automatic rd_txn(input string tag, input logic [31:0] a, input logic exp_rden,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.S_AXI_RREADY = 1'b1;
        chk({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'h1);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        chk({tag, "_rden"},   32'(rden), 32'(exp_rden));
        chk({tag, "_araddr"}, axi_araddr, a & 32'hFFFF_FFFC);
        tick();
        chk({tag, "_rv_early"}, 32'(bus.S_AXI_RVALID), 32'h0);
        tick();
        chk({tag, "_rvalid"}, 32'(bus.S_AXI_RVALID), 32'h1);
        chk({tag, "_rdata"},  bus.S_AXI_RDATA, exp_data);
        chk({tag, "_rresp"},  32'(bus.S_AXI_RRESP), 32'(exp_resp));
        tick();
        chk({tag, "_rv_drop"}, 32'(bus.S_AXI_RVALID), 32'h0);
    endtask

    initial begin
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_ctrl", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                             bus.S_AXI_BVALID, bus.S_AXI_RVALID, wren, rden}), 32'h0);
        chk("rst_addr", axi_awaddr | axi_araddr, 32'h0);
        chk("rst_data", wdata_ext | bus.S_AXI_RDATA, 32'h0);
        chk("rst_resp", 32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 32'h7);

        // AW and W together
        wr_both(32'h4000_F004, 32'hA5A5_0001, 4'hF);
        chk("wA_rdy_low", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h0);
        wr_finish("wA", 32'h4000_F004, 32'hA5A5_0001, 1'b1, 2'b00);

        // W three cycles ahead of AW
        bus.S_AXI_WDATA  = 32'h0000_1000;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        chk("wB_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h2);
        tick();
        chk("wB_nowren1", 32'(wren), 32'h0);
        tick();
        chk("wB_nowren2", 32'(wren), 32'h0);
        bus.S_AXI_AWADDR  = 32'h4000_F00C;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        wr_finish("wB", 32'h4000_F00C, 32'h0000_1000, 1'b1, 2'b00);

        // AW five cycles ahead of W
        bus.S_AXI_AWADDR  = 32'h4000_F00C;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        chk("wC_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'h1);
        repeat (4) tick();
        chk("wC_nowren", 32'(wren), 32'h0);
        bus.S_AXI_WDATA  = 32'h0000_1000;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        wr_finish("wC", 32'h4000_F00C, 32'h0000_1000, 1'b1, 2'b00);

        // Read with RREADY held low; a stray AR during the hold is ignored
        bus.S_AXI_RREADY  = 1'b0;
        chk("rA_arready", 32'(bus.S_AXI_ARREADY), 32'h1);
        bus.S_AXI_ARADDR  = 32'h4000_F00C;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        chk("rA_rden", 32'(rden), 32'h1);
        chk("rA_araddr", axi_araddr, 32'h4000_F00C);
        tick();
        chk("rA_rv_early", 32'(bus.S_AXI_RVALID), 32'h0);
        tick();
        chk("rA_rvalid", 32'(bus.S_AXI_RVALID), 32'h1);
        chk("rA_rdata", bus.S_AXI_RDATA, 32'h0000_1000);
        chk("rA_rresp", 32'(bus.S_AXI_RRESP), 32'h0);
        bus.S_AXI_ARADDR  = 32'h4000_F000;
        bus.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rA_hold", 32'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, rden}), 32'h4);
            chk("rA_hold_data", bus.S_AXI_RDATA, 32'h0000_1000);
        end
        chk("rA_araddr_keep", axi_araddr, 32'h4000_F00C);
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        tick();
        chk("rA_done", 32'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 32'h1);

        // Unaligned read acts on the containing word
        rd_txn("rUnal", 32'h4000_F00E, 1'b1, 32'h0000_1000, 2'b00);

        // Out-of-range and bad-strobe cases
        wr_both(32'h5000_0000, 32'h1234_5678, 4'hF);
        wr_finish("wOOR", 32'h5000_0000, 32'h1234_5678, 1'b0, 2'b11);
        rd_txn("rOOR", 32'h3FFF_FFFC, 1'b0, 32'h0, 2'b11);
        wr_both(32'h4000_F000, 32'h0000_00FF, 4'h3);
        wr_finish("wPart", 32'h4000_F000, 32'h0000_00FF, 1'b0, 2'b10);
        wr_both(32'h4000_F000, 32'h0000_00FF, 4'h0);
        wr_finish("wZero", 32'h4000_F000, 32'h0000_00FF, 1'b0, 2'b10);
        wr_both(32'h4001_0000, 32'h0000_0001, 4'h3);
        wr_finish("wOORpri", 32'h4001_0000, 32'h0000_0001, 1'b0, 2'b11);
        wr_both(32'h4000_FFFC, 32'h0BAD_F00D, 4'hF);
        wr_finish("wTop", 32'h4000_FFFC, 32'h0BAD_F00D, 1'b1, 2'b00);
        rd_txn("rTop", 32'h4000_FFFC, 1'b1, 32'h0BAD_F00D, 2'b00);

        // Concurrent write and read to the same word
        wr_both(32'h4000_F008, 32'h1111_2222, 4'hF);
        wr_finish("wE0", 32'h4000_F008, 32'h1111_2222, 1'b1, 2'b00);
        chk("cc_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 32'h7);
        bus.S_AXI_AWADDR  = 32'h4000_F008;
        bus.S_AXI_WDATA   = 32'h3333_4444;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_ARADDR  = 32'h4000_F008;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        chk("cc_strobes", 32'({wren, rden}), 32'h3);
        tick();
        chk("cc_b", 32'({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_RVALID}), 32'h8);
        tick();
        chk("cc_r", 32'({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RRESP}), 32'h4);
        chk("cc_rdata_old", bus.S_AXI_RDATA, 32'h1111_2222);
        tick();
        rd_txn("ccNew", 32'h4000_F008, 1'b1, 32'h3333_4444, 2'b00);

        // Reset while the write waits for AW (one step before W_EXEC) and the
        // read sits in R_WAIT
        bus.S_AXI_WDATA  = 32'hDEAD_BEEF;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARADDR  = 32'h4000_F008;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        chk("rst_mid_rden", 32'(rden), 32'h1);
        tick();
        bus.S_AXI_AWADDR  = 32'h4000_F008;
        bus.S_AXI_AWVALID = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 32'({bus.S_AXI_AWREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, wren, rden}), 32'h0);
        chk("rst_mid_rdata", bus.S_AXI_RDATA, 32'h0);
        bus.S_AXI_AWVALID = 1'b0;
        begin
            int c0;
            c0 = wren_cnt;
            tick();
            tick();
            chk("rst_hold", 32'({bus.S_AXI_BVALID, bus.S_AXI_RVALID, wren, rden}), 32'h0);
            rst_n = 1'b1;
            tick();
            chk("rst_rel_rdy", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                                    bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 32'h1C);
            tick();
            chk("rst_no_wren", 32'(wren_cnt - c0), 32'h0);
        end
        wr_both(32'h4000_F010, 32'h5555_AAAA, 4'hF);
        wr_finish("wPost", 32'h4000_F010, 32'h5555_AAAA, 1'b1, 2'b00);
        rd_txn("rPost", 32'h4000_F010, 1'b1, 32'h5555_AAAA, 2'b00);
        rd_txn("rKept", 32'h4000_F008, 1'b1, 32'h3333_4444, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
